// File: rtl/chess_timer_pkg.sv
// rtl/chess_timer_pkg.sv - shared constants and saturating add for the chess clock timers
package chess_timer_pkg;

  localparam int P1_IDX      = 0;
  localparam int P2_IDX      = 1;
  localparam int SEC_W       = 10;
  localparam int DEF_MAX_SEC = 999;

  // Sum is formed one bit wider so the ceiling check sees any carry out.
  function automatic logic [SEC_W-1:0] sat_add(input logic [SEC_W-1:0] v,
                                               input logic [SEC_W:0]   inc,
                                               input logic [SEC_W-1:0] max_v);
    logic [SEC_W:0] sum;
    sum = {1'b0, v} + inc;
    if (sum > {1'b0, max_v})
      return max_v;
    else
      return sum[SEC_W-1:0];
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - one-second prescaler with synchronous clear and wrap pulse
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic wrap
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign wrap = run && !clear && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (run)
      count <= wrap ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/chess_time_counters.sv
// rtl/chess_time_counters.sv - dual per-player countdown seconds with load, bonus and expiry
module chess_time_counters
  import chess_timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int INC_SEC  = 0,
  parameter int MAX_SEC  = DEF_MAX_SEC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       load_counters,
  input  logic [1:0]       en_counters,
  input  logic [SEC_W-1:0] init_seconds,
  output logic [SEC_W-1:0] counter_1,
  output logic [SEC_W-1:0] counter_2,
  output logic [1:0]       expired,
  output logic             tick
);

  localparam logic [SEC_W-1:0] MAX_V = SEC_W'(MAX_SEC);
  localparam logic [SEC_W:0]   INC_V = (SEC_W+1)'(INC_SEC);

  logic [SEC_W-1:0] cnt [2];
  logic [1:0]       en_prev;
  logic             en_legal;
  logic             clear;
  logic             wrap;
  logic [SEC_W-1:0] load_val;

  assign en_legal = (en_counters == 2'b01) || (en_counters == 2'b10);
  // Any load, stop or change of running player restarts the second from zero.
  assign clear    = (|load_counters) || !en_legal || (en_counters != en_prev);
  assign load_val = (init_seconds > MAX_V) ? MAX_V : init_seconds;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .run  (en_legal),
    .wrap (wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt[P1_IDX] <= '0;
      cnt[P2_IDX] <= '0;
      en_prev     <= 2'b00;
      tick        <= 1'b0;
    end else begin
      en_prev <= en_counters;
      tick    <= wrap;
      for (int i = 0; i < 2; i++) begin
        if (load_counters[i])
          cnt[i] <= load_val;
        else if (INC_SEC != 0 && en_prev[i] && !en_counters[i] && cnt[i] != '0)
          cnt[i] <= sat_add(cnt[i], INC_V, MAX_V);
        else if (wrap && en_counters[i] && cnt[i] != '0)
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  assign counter_1 = cnt[P1_IDX];
  assign counter_2 = cnt[P2_IDX];
  assign expired   = {cnt[P2_IDX] == '0, cnt[P1_IDX] == '0};

endmodule

// File: tb/tb_chess_time_counters.sv
// tb/tb_chess_time_counters.sv - directed self-checking bench for chess_time_counters
module tb_chess_time_counters;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] load_counters;
  logic [1:0] en_counters;
  logic [9:0] init_seconds;
  logic [9:0] counter_1;
  logic [9:0] counter_2;
  logic [1:0] expired;
  logic       tick;

  int vectors = 0;
  int miscompares = 0;

  chess_time_counters #(
    .TICK_DIV(4),
    .INC_SEC (2),
    .MAX_SEC (999)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_counters(load_counters),
    .en_counters  (en_counters),
    .init_seconds (init_seconds),
    .counter_1    (counter_1),
    .counter_2    (counter_2),
    .expired      (expired),
    .tick         (tick)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_counters = 2'b00; en_counters = 2'b00; init_seconds = 10'd0;
    cyc(); cyc();
    vectors++; if (counter_1 !== 10'd0) begin miscompares++; $display("FAIL reset_c1: got %0d expected 0", counter_1); end
    vectors++; if (counter_2 !== 10'd0) begin miscompares++; $display("FAIL reset_c2: got %0d expected 0", counter_2); end
    vectors++; if (expired !== 2'b11) begin miscompares++; $display("FAIL reset_expired: got %b expected 11", expired); end
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b expected 0", tick); end
    reset = 1'b0;
  endtask

  task automatic test_load();
    load_counters = 2'b11; init_seconds = 10'd5;
    cyc();
    load_counters = 2'b00;
    vectors++; if (counter_1 !== 10'd5) begin miscompares++; $display("FAIL load_c1: got %0d expected 5", counter_1); end
    vectors++; if (counter_2 !== 10'd5) begin miscompares++; $display("FAIL load_c2: got %0d expected 5", counter_2); end
    vectors++; if (expired !== 2'b00) begin miscompares++; $display("FAIL load_expired: got %b expected 00", expired); end
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL load_tick: got %b expected 0", tick); end
  endtask

  task automatic test_run_to_expiry();
    int k;
    logic [9:0] exp_c1;
    logic exp_tick;
    en_counters = 2'b01;
    for (int e = 1; e <= 26; e++) begin
      cyc();
      if (e < 5) exp_c1 = 10'd5;
      else begin
        k = (e - 5) / 4 + 1;
        exp_c1 = (k >= 5) ? 10'd0 : 10'(5 - k);
      end
      exp_tick = (e >= 5) && (((e - 5) % 4) == 0);
      vectors++; if (counter_1 !== exp_c1) begin miscompares++; $display("FAIL run_c1 edge %0d: got %0d expected %0d", e, counter_1, exp_c1); end
      vectors++; if (tick !== exp_tick) begin miscompares++; $display("FAIL run_tick edge %0d: got %b expected %b", e, tick, exp_tick); end
      vectors++; if (counter_2 !== 10'd5) begin miscompares++; $display("FAIL run_c2 edge %0d: got %0d expected 5", e, counter_2); end
    end
    vectors++; if (expired !== 2'b01) begin miscompares++; $display("FAIL run_expired: got %b expected 01", expired); end
  endtask

  task automatic test_turn_switch();
    logic [9:0] exp_c2;
    load_counters = 2'b01; init_seconds = 10'd3;
    cyc();
    load_counters = 2'b00;
    vectors++; if (counter_1 !== 10'd3) begin miscompares++; $display("FAIL switch_preload_c1: got %0d expected 3", counter_1); end
    en_counters = 2'b10;
    for (int e = 1; e <= 6; e++) begin
      cyc();
      exp_c2 = (e < 5) ? 10'd5 : 10'd4;
      vectors++; if (counter_1 !== 10'd5) begin miscompares++; $display("FAIL switch_c1 edge %0d: got %0d expected 5", e, counter_1); end
      vectors++; if (counter_2 !== exp_c2) begin miscompares++; $display("FAIL switch_c2 edge %0d: got %0d expected %0d", e, counter_2, exp_c2); end
      vectors++; if (tick !== (e == 5)) begin miscompares++; $display("FAIL switch_tick edge %0d: got %b expected %b", e, tick, (e == 5)); end
    end
  endtask

  task automatic test_saturation();
    load_counters = 2'b11; init_seconds = 10'd1023;
    cyc();
    vectors++; if (counter_1 !== 10'd999) begin miscompares++; $display("FAIL sat_load_c1: got %0d expected 999", counter_1); end
    vectors++; if (counter_2 !== 10'd999) begin miscompares++; $display("FAIL sat_load_c2: got %0d expected 999", counter_2); end
    load_counters = 2'b01; init_seconds = 10'd998;
    cyc();
    load_counters = 2'b00; en_counters = 2'b01;
    cyc();
    vectors++; if (counter_2 !== 10'd999) begin miscompares++; $display("FAIL sat_inc_c2: got %0d expected 999", counter_2); end
    en_counters = 2'b10;
    cyc();
    vectors++; if (counter_1 !== 10'd999) begin miscompares++; $display("FAIL sat_inc_c1: got %0d expected 999", counter_1); end
    load_counters = 2'b01; init_seconds = 10'd0;
    cyc();
    load_counters = 2'b00; en_counters = 2'b01;
    cyc();
    en_counters = 2'b10;
    cyc();
    vectors++; if (counter_1 !== 10'd0) begin miscompares++; $display("FAIL sat_zero_c1: got %0d expected 0", counter_1); end
    vectors++; if (expired !== 2'b01) begin miscompares++; $display("FAIL sat_zero_expired: got %b expected 01", expired); end
  endtask

  task automatic test_illegal_and_priority();
    load_counters = 2'b11; init_seconds = 10'd7;
    cyc();
    load_counters = 2'b00; en_counters = 2'b11;
    for (int e = 1; e <= 20; e++) begin
      cyc();
      vectors++; if (counter_1 !== 10'd7 || counter_2 !== 10'd7) begin miscompares++; $display("FAIL illegal_hold edge %0d: got %0d/%0d expected 7/7", e, counter_1, counter_2); end
      vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL illegal_tick edge %0d: got %b expected 0", e, tick); end
    end
    en_counters = 2'b01;
    cyc();
    vectors++; if (counter_2 !== 10'd9) begin miscompares++; $display("FAIL illegal_exit_inc_c2: got %0d expected 9", counter_2); end
    cyc(); cyc(); cyc();
    vectors++; if (counter_1 !== 10'd7) begin miscompares++; $display("FAIL prio_pre_c1: got %0d expected 7", counter_1); end
    load_counters = 2'b01; init_seconds = 10'd20;
    cyc();
    load_counters = 2'b00;
    vectors++; if (counter_1 !== 10'd20) begin miscompares++; $display("FAIL prio_load_c1: got %0d expected 20", counter_1); end
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL prio_load_tick: got %b expected 0", tick); end
    vectors++; if (counter_2 !== 10'd9) begin miscompares++; $display("FAIL prio_load_c2: got %0d expected 9", counter_2); end
    cyc(); cyc(); cyc();
    vectors++; if (counter_1 !== 10'd20) begin miscompares++; $display("FAIL prio_restart_c1: got %0d expected 20", counter_1); end
    cyc();
    vectors++; if (counter_1 !== 10'd19) begin miscompares++; $display("FAIL prio_next_dec_c1: got %0d expected 19", counter_1); end
    vectors++; if (tick !== 1'b1) begin miscompares++; $display("FAIL prio_next_tick: got %b expected 1", tick); end
  endtask

  task automatic test_reset_mid_count();
    en_counters = 2'b01;
    cyc(); cyc(); cyc();
    reset = 1'b1;
    cyc();
    vectors++; if (counter_1 !== 10'd0 || counter_2 !== 10'd0) begin miscompares++; $display("FAIL midreset_counters: got %0d/%0d expected 0/0", counter_1, counter_2); end
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL midreset_tick: got %b expected 0", tick); end
    vectors++; if (expired !== 2'b11) begin miscompares++; $display("FAIL midreset_expired: got %b expected 11", expired); end
    reset = 1'b0; en_counters = 2'b00;
    cyc(); cyc();
    vectors++; if (counter_1 !== 10'd0 || counter_2 !== 10'd0) begin miscompares++; $display("FAIL midreset_no_inc: got %0d/%0d expected 0/0", counter_1, counter_2); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_run_to_expiry();
    test_turn_switch();
    test_saturation();
    test_illegal_and_priority();
    test_reset_mid_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chess_time_counters.md
# chess_time_counters

Dual per-player countdown timer for the DE10 chess clock. It holds each player's remaining time in whole seconds and derives a 1 Hz decrement tick from the board clock. It applies an optional per-move bonus increment and reports the remaining time and expiry to the chess-timer control FSM. The block consumes the FSM's `load_counters`/`en_counters` and feeds back `counter_1`/`counter_2`.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: clock cycles per one-second tick (≥2).
- `INC_SEC`, default 0: bonus seconds added when a player's turn ends (0 disables).
- `MAX_SEC`, default 999: saturation ceiling for any counter value (≤1023).

Ports:
- `clk`, input, 1: system clock. One clock domain.
- `reset`, input, 1: synchronous, active-high.
- `load_counters`, input, 2: bit i loads player i+1 from `init_seconds`.
- `en_counters`, input, 2: bit i means player i+1's clock is running. 01 and 10 are legal; 11 is treated as stopped.
- `init_seconds`, input, 10: starting time from switches, binary seconds.
- `counter_1`, output, 10: player 1 remaining seconds (registered).
- `counter_2`, output, 10: player 2 remaining seconds (registered).
- `expired`, output, 2: bit i high when the player's counter equals 0 (decoded from registers).
- `tick`, output, 1: one-cycle pulse in the cycle a decrement becomes visible.

## Operation
- **Reset:** both counters 0, prescaler 0, `en_prev` 00, `tick` 0, `expired` 11.
- **Prescaler** counts 0…TICK_DIV-1 only while `en_counters` is 01 or 10.
  - It is cleared when any `load_counters` bit is set, when `en_counters` is 00 or 11, or when `en_counters` differs from `en_prev` (the registered previous value).
  - On wrap from TICK_DIV-1 to 0, a decrement event fires.
- **Decrement event:** the counter whose `en` bit is set decrements by 1 if it is nonzero. At 0 it holds (no underflow) and `tick` still pulses.
- **Load:** `load_counters[i]` sets counter i to min(`init_seconds`, MAX_SEC). Load has highest priority: it beats a decrement and an increment in the same cycle.
- **Increment:** fires when `en_prev[i]`=1, `en_counters[i]`=0, `load_counters[i]`=0 and counter i ≠ 0. The new value is counter i ← min(counter i + INC_SEC, MAX_SEC).
  - The sum is computed at 11 bits before saturation.
  - An expired player never receives the bonus.
- **Priority per counter:** reset > load > increment > decrement > hold.
- The two counters are updated independently in the same cycle. A switch 01→10 can increment player 1 while player 2's prescaler restarts.

## Timing
- **Load:** new value visible on the cycle after `load_counters` is sampled high.
- **First decrement:** visible TICK_DIV+1 cycles after the first cycle in which a new legal `en_counters` value is sampled. The clear takes one cycle, then TICK_DIV counts.
- **Subsequent decrements:** every TICK_DIV cycles while `en_counters` is unchanged.
- **`tick`:** registered, high exactly in the cycle the decremented value first appears.
- **Increment:** visible the cycle after the `en` falling edge is sampled.
- **`expired`:** follows the counter registers combinationally, with zero added latency.
- **Reset mid-count:** takes effect at the next edge. `en_prev` is cleared, so no increment fires on the first post-reset `en` fall.

## Structure
- Shared `chess_timer_pkg`:
  - player index constants `P1_IDX`=0 and `P2_IDX`=1;
  - `SEC_W`=10;
  - default `MAX_SEC`.
- Sub-module `tick_prescaler`, parameter TICK_DIV, width $clog2(TICK_DIV):
  - inputs `clk`, `reset`, `clear`, `run`;
  - output `wrap` pulse.
- Top level holds the two counter registers, `en_prev`, the saturation arithmetic and the `tick` register.

## Test plan
All scenarios use TICK_DIV=4 and INC_SEC=2.
- **Load:** reset, then `load_counters`=11 with `init_seconds`=5 → both counters 5 on the next cycle, `expired`=00, `tick` 0.
- **Run to expiry:** hold `en_counters`=01 → `counter_1` becomes 4 five cycles after `en` is first sampled, then drops by 1 every 4 cycles. It reaches 0 and holds, `expired[0]`=1, `counter_2` stays 5, and `tick` keeps pulsing.
- **Turn switch:** `counter_1`=3, switch `en` 01→10 → `counter_1`=5 on the next cycle; `counter_2` first decrements 5 cycles after the switch.
- **Saturation:** load `init_seconds`=1023 → 999. A counter at 998 ending its turn → 999. A counter at 0 ending its turn stays 0.
- **Illegal enable and load priority:** `en_counters`=11 for 20 cycles → no counter change, `tick` 0. Asserting `load_counters[0]` in the same cycle a decrement is due → load value wins, no decrement.
- **Reset mid-count:** assert `reset` mid-count with `en`=01 → counters 0 and `tick` 0 next cycle. Release with `en`=00 → no increment applied.
